// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch FSM states and default widths / reset PC.
package proc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } fetch_state_e;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;

  // Shared with the instruction register so both agree on the boot address.
  localparam logic [7:0] DefResetPc = 8'h00;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives reads into the instruction register, waits a fixed
// latency, and hands each instruction plus its PC to decode over valid/ready.
module inst_fetch
  import proc_pkg::*;
#(
  parameter int unsigned        ADDR_W   = DefAddrW,
  parameter int unsigned        DATA_W   = DefDataW,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DefResetPc),
  parameter int unsigned        MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_active,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              busy
);

  // Count value at which mem_data is valid for the held address.
  localparam logic [2:0] LatMax = 3'(MEM_LAT);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_data_q, inst_data_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

  // Next-state logic; redirect overrides handshake/halt, which override start.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_addr_d   = mem_addr_q;
    lat_cnt_d    = lat_cnt_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;

    if (redirect_valid) begin
      pc_d         = redirect_addr;
      inst_valid_d = 1'b0;
      lat_cnt_d    = 3'd0;
      // In IDLE only the PC moves; fetching waits for start.
      if (state_q != StIdle) begin
        state_d    = StFetch;
        mem_addr_d = redirect_addr;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !halt) begin
            state_d    = StFetch;
            mem_addr_d = pc_q;
            lat_cnt_d  = 3'd0;
          end
        end
        StFetch: begin
          if (lat_cnt_q == LatMax) begin
            inst_data_d  = mem_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + ADDR_W'(1);
            state_d      = StHold;
          end else begin
            lat_cnt_d = lat_cnt_q + 3'd1;
          end
        end
        StHold: begin
          if (inst_valid_q && inst_ready) begin
            inst_valid_d = 1'b0;
            if (halt) begin
              state_d = StIdle;
            end else begin
              state_d    = StFetch;
              mem_addr_d = pc_q;
              lat_cnt_d  = 3'd0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      mem_addr_q   <= RESET_PC;
      lat_cnt_q    <= 3'd0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_addr_q   <= mem_addr_d;
      lat_cnt_q    <= lat_cnt_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // Outputs: read request follows FETCH directly, everything else is registered.
  always_comb begin
    mem_active = (state_q == StFetch);
    busy       = (state_q != StIdle);
    mem_addr   = mem_addr_q;
    inst_valid = inst_valid_q;
    inst_data  = inst_data_q;
    inst_pc    = inst_pc_q;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a 1-cycle registered instruction memory and a
// scoreboard of expected deliveries popped on every handshake.
module tb_inst_fetch;

  logic       clk;
  logic       rst;
  logic       start;
  logic       halt;
  logic       redirect_valid;
  logic [7:0] redirect_addr;
  logic       mem_active;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       inst_valid;
  logic [7:0] inst_data;
  logic [7:0] inst_pc;
  logic       inst_ready;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] pc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] mem [256];
  int         checks = 0;
  int         errors = 0;

  inst_fetch #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .RESET_PC(8'h00),
    .MEM_LAT (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .halt          (halt),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .mem_active    (mem_active),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction register model: data valid one edge after the address is presented.
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] p);
    exp_t e;
    e.data = d;
    e.pc   = p;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    start          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("rst_valid", inst_valid, 0);
    chk("rst_active", mem_active, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
  endtask

  // Scoreboard: every handshake must match the oldest expected delivery.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed data=%0h pc=%0h expected none", inst_data, inst_pc);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sb_data", inst_data, mon_e.data);
        chk("sb_pc", inst_pc, mon_e.pc);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h02;
    mem[8'h01] = 8'h06;
    mem[8'h40] = 8'hA5;
    mem[8'hFF] = 8'h3C;
    redirect_addr = 8'h00;
    inst_ready    = 1'b1;

    // Sequential fetch, ready tied high.
    do_reset();
    push(8'h02, 8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f1_active0", mem_active, 1);
    chk("f1_addr", mem_addr, 8'h00);
    chk("f1_busy", busy, 1);
    chk("f1_novalid", inst_valid, 0);
    tick();
    chk("f1_active1", mem_active, 1);
    chk("f1_novalid1", inst_valid, 0);
    tick();
    chk("f1_valid", inst_valid, 1);
    chk("f1_idle_mem", mem_active, 0);
    push(8'h06, 8'h01);
    tick();
    chk("f2_addr", mem_addr, 8'h01);
    chk("f2_active", mem_active, 1);
    chk("f2_novalid", inst_valid, 0);
    tick();
    chk("f2_active1", mem_active, 1);
    tick();
    chk("f2_valid", inst_valid, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("f2_halt_busy", busy, 0);
    chk("f2_halt_active", mem_active, 0);

    // Backpressure: hold the first instruction for 5 cycles.
    do_reset();
    inst_ready = 1'b0;
    push(8'h02, 8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", inst_valid, 1);
      chk("bp_data", inst_data, 8'h02);
      chk("bp_pc", inst_pc, 8'h00);
      chk("bp_active", mem_active, 0);
      chk("bp_addr", mem_addr, 8'h00);
      if (i != 4) tick();
    end
    push(8'h06, 8'h01);
    inst_ready = 1'b1;
    tick();
    chk("bp_next_active", mem_active, 1);
    chk("bp_next_addr", mem_addr, 8'h01);
    tick();
    tick();
    chk("bp_next_valid", inst_valid, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;

    // Redirect in the first FETCH cycle.
    do_reset();
    start = 1'b1;
    tick();
    start          = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 8'h40;
    push(8'hA5, 8'h40);
    tick();
    redirect_valid = 1'b0;
    chk("rd_addr", mem_addr, 8'h40);
    chk("rd_active", mem_active, 1);
    chk("rd_novalid", inst_valid, 0);
    tick();
    chk("rd_novalid1", inst_valid, 0);
    tick();
    chk("rd_valid", inst_valid, 1);
    chk("rd_data", inst_data, 8'hA5);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("rd_halt_busy", busy, 0);

    // Redirect in IDLE to 0xFF, then PC wrap.
    do_reset();
    redirect_valid = 1'b1;
    redirect_addr  = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    chk("wr_idle_busy", busy, 0);
    chk("wr_idle_addr", mem_addr, 8'h00);
    push(8'h3C, 8'hFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wr_addr", mem_addr, 8'hFF);
    tick();
    tick();
    chk("wr_valid", inst_valid, 1);
    push(8'h02, 8'h00);
    tick();
    chk("wr_wrap_addr", mem_addr, 8'h00);
    chk("wr_wrap_active", mem_active, 1);
    tick();
    tick();
    chk("wr_wrap_valid", inst_valid, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;

    // Halt held through FETCH, then restart; start+halt in IDLE is ignored.
    do_reset();
    push(8'h02, 8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    halt  = 1'b1;
    tick();
    tick();
    chk("ht_valid", inst_valid, 1);
    chk("ht_data", inst_data, 8'h02);
    tick();
    chk("ht_busy", busy, 0);
    chk("ht_active", mem_active, 0);
    chk("ht_novalid", inst_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ht_starthalt_busy", busy, 0);
    halt = 1'b0;
    push(8'h06, 8'h01);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ht_restart_addr", mem_addr, 8'h01);
    tick();
    tick();
    chk("ht_restart_valid", inst_valid, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;

    // Reset while holding an undelivered instruction.
    do_reset();
    inst_ready = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rh_hold_valid", inst_valid, 1);
    do_reset();
    inst_ready = 1'b1;
    push(8'h02, 8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rh_addr", mem_addr, 8'h00);
    tick();
    tick();
    chk("rh_valid", inst_valid, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();

    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
